alu_result_fifo: RTL and testbench

//  Downstream stage of the 32-bit ALU: captures each ALU result with its flags (out, Zero, Overflow,

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_result_fifo_if.sv | 42 ++++
 rtl/alu_result_mem.sv | 27 ++
 rtl/alu_result_fifo.sv | 116 +++++++++++
 tb/tb_alu_result_fifo.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-select encodings, data width, op width and
// the width of one buffered result entry {op, cout, overflow, zero, result}.
package alu_pkg;

    localparam int ALU_WIDTH   = 32;
    localparam int ALU_OP_W    = 3;
    localparam int ALU_ENTRY_W = ALU_WIDTH + 3 + ALU_OP_W;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_OP_ADD = 3'b000,
        ALU_OP_SUB = 3'b001,
        ALU_OP_AND = 3'b010,
        ALU_OP_OR  = 3'b011,
        ALU_OP_XOR = 3'b100,
        ALU_OP_SLT = 3'b101,
        ALU_OP_SLL = 3'b110,
        ALU_OP_SRL = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU, the result FIFO and its consumer.
//   in_*  : producer side (valid/ready, result, flags, op select)
//   out_* : consumer side (valid/ready, head result, flags, op select)
//   count : occupied entries, 0..DEPTH
// Modports: slave = the FIFO, master = the ALU/consumer environment.
interface alu_result_fifo_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4,
    parameter int OP_W  = ALU_OP_W
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_result;
    logic                   in_zero;
    logic                   in_overflow;
    logic                   in_cout;
    logic [OP_W-1:0]        in_op;

    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_result;
    logic                   out_zero;
    logic                   out_overflow;
    logic                   out_cout;
    logic [OP_W-1:0]        out_op;

    logic [$clog2(DEPTH):0] count;

    modport slave (
        input  in_valid, in_result, in_zero, in_overflow, in_cout, in_op, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_overflow, out_cout, out_op,
               count
    );

    modport master (
        output in_valid, in_result, in_zero, in_overflow, in_cout, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_overflow, out_cout, out_op,
               count
    );
endinterface

// File: rtl/alu_result_mem.sv
// Entry storage for the ALU result FIFO: DEPTH x ENTRY_W, one synchronous
// write port and one asynchronous read port (read data follows raddr).
// Ports: clk, we, waddr, wdata, raddr, rdata. Contents are not reset.
module alu_result_mem
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = ALU_ENTRY_W,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);
    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/alu_result_fifo.sv
// First-word-fall-through buffer behind the 32-bit ALU. Captures
// {op, cout, overflow, zero, result} on each accepted push and presents the
// oldest entry to the consumer through a valid/ready handshake.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : in_* producer channel, out_* consumer channel, count
// Optional feature (macro ALU_RESULT_STICKY_EN):
//   sticky_clr        : in,  clears the sticky overflow flag
//   sticky_overflow   : out, set by any accepted push carrying overflow=1;
//                       a set in the same cycle as a clear wins
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4,
    parameter int OP_W  = ALU_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_result_fifo_if.slave  bus
`ifdef ALU_RESULT_STICKY_EN
    ,
    input  logic              sticky_clr,
    output logic              sticky_overflow
`endif
);
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRY_W = WIDTH + 3 + OP_W;

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] rdata;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // in_ready depends only on full, so a full FIFO never accepts even when
    // the head is popped in the same cycle.
    assign push = bus.in_valid && !full;
    assign pop  = bus.out_ready && !empty;

    assign wdata = {bus.in_op, bus.in_cout, bus.in_overflow, bus.in_zero, bus.in_result};

    alu_result_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W),
        .AW      (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.count     = count;

    // Storage is never cleared, so head data is masked while empty.
    always_comb begin
        bus.out_result   = '0;
        bus.out_zero     = 1'b0;
        bus.out_overflow = 1'b0;
        bus.out_cout     = 1'b0;
        bus.out_op       = '0;
        if (!empty) begin
            bus.out_result   = rdata[WIDTH-1:0];
            bus.out_zero     = rdata[WIDTH];
            bus.out_overflow = rdata[WIDTH+1];
            bus.out_cout     = rdata[WIDTH+2];
            bus.out_op       = rdata[ENTRY_W-1 -: OP_W];
        end
    end

`ifdef ALU_RESULT_STICKY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_overflow <= 1'b0;
        end else if (push && bus.in_overflow) begin
            sticky_overflow <= 1'b1;
        end else if (sticky_clr) begin
            sticky_overflow <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized and directed bench for alu_result_fifo against a queue model.
module tb_alu_result_fifo;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        overflow;
        logic        cout;
        logic [2:0]  op;
    } ent_t;

    logic clk;
    logic rst_n;
    logic sticky_clr;
    logic sticky_overflow;

    int n_checks;
    int n_errors;

    ent_t q[$];
    logic sticky_exp;

    alu_result_fifo_if #(.WIDTH(32), .DEPTH(DEPTH), .OP_W(3)) bus ();

    alu_result_fifo #(.WIDTH(32), .DEPTH(DEPTH), .OP_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ALU_RESULT_STICKY_EN
        ,
        .sticky_clr      (sticky_clr),
        .sticky_overflow (sticky_overflow)
`endif
    );

`ifndef ALU_RESULT_STICKY_EN
    assign sticky_overflow = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        ent_t h;
        h = '{result: 32'h0, zero: 1'b0, overflow: 1'b0, cout: 1'b0, op: 3'b0};
        if (q.size() > 0) h = q[0];
        check("count",        64'(bus.count),        64'(q.size()));
        check("in_ready",     64'(bus.in_ready),     64'(q.size() < DEPTH));
        check("out_valid",    64'(bus.out_valid),    64'(q.size() > 0));
        check("out_result",   64'(bus.out_result),   64'(h.result));
        check("out_zero",     64'(bus.out_zero),     64'(h.zero));
        check("out_overflow", 64'(bus.out_overflow), 64'(h.overflow));
        check("out_cout",     64'(bus.out_cout),     64'(h.cout));
        check("out_op",       64'(bus.out_op),       64'(h.op));
`ifdef ALU_RESULT_STICKY_EN
        check("sticky_overflow", 64'(sticky_overflow), 64'(sticky_exp));
`endif
    endtask

    // One clock: check state at the falling edge, then advance the model on
    // the rising edge using the inputs that were stable across it.
    task automatic cycle();
        bit   do_push;
        bit   do_pop;
        ent_t e;
        @(negedge clk);
        check_outputs();
        do_push = bus.in_valid && (q.size() < DEPTH);
        do_pop  = bus.out_ready && (q.size() > 0);
        e = '{result: bus.in_result, zero: bus.in_zero, overflow: bus.in_overflow,
              cout: bus.in_cout, op: bus.in_op};
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
        if (do_push && e.overflow) sticky_exp = 1'b1;
        else if (sticky_clr) sticky_exp = 1'b0;
        #1;
    endtask

    task automatic drive(input bit valid, input logic [31:0] result, input bit zero,
                         input bit ovf, input bit cout, input logic [2:0] op,
                         input bit ready);
        bus.in_valid    = valid;
        bus.in_result   = result;
        bus.in_zero     = zero;
        bus.in_overflow = ovf;
        bus.in_cout     = cout;
        bus.in_op       = op;
        bus.out_ready   = ready;
    endtask

    task automatic idle(input bit ready);
        drive(1'b0, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), ready);
    endtask

    task automatic apply_reset();
        idle(1'b0);
        sticky_clr = 1'b0;
        rst_n = 1'b0;
        #2;
        q.delete();
        sticky_exp = 1'b0;
        check("rst_count",      64'(bus.count),      64'd0);
        check("rst_out_valid",  64'(bus.out_valid),  64'd0);
        check("rst_in_ready",   64'(bus.in_ready),   64'd1);
        check("rst_out_result", 64'(bus.out_result), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        sticky_exp = 1'b0;
        rst_n      = 1'b1;
        sticky_clr = 1'b0;
        idle(1'b0);
        #3;
        apply_reset();

        // Single zero-result push, then pop.
        drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        cycle();
        idle(1'b0);
        cycle();
        idle(1'b1);
        cycle();
        cycle();

        // Fill with 1..4, a fifth push must be dropped, then drain in order.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 3'(i), 1'b0);
            cycle();
        end
        // Full with pop: no push accepted in the same cycle.
        drive(1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 3'b110, 1'b1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            cycle();
        end

        // Steady state at count=2 with simultaneous push and pop.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b1, ALU_OP_SUB, 1'b0);
            cycle();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 1'($urandom), 1'b0, 1'($urandom), 3'($urandom), 1'b1);
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            cycle();
        end

        // Signed overflow from 7FFF_FFFF + 1 with no carry out.
        drive(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, ALU_OP_ADD, 1'b0);
        cycle();
        idle(1'b0);
        cycle();

        // Sticky flag: set beats clear in the same cycle, clear alone drops it.
        drive(1'b1, 32'h8000_0001, 1'b0, 1'b1, 1'b0, ALU_OP_ADD, 1'b1);
        sticky_clr = 1'b1;
        cycle();
        idle(1'b1);
        sticky_clr = 1'b0;
        cycle();
        sticky_clr = 1'b1;
        cycle();
        sticky_clr = 1'b0;
        cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 1'($urandom),
                  1'($urandom), 3'($urandom), 1'($urandom_range(0, 2) != 0));
            sticky_clr = ($urandom_range(0, 7) == 0);
            cycle();
        end
        sticky_clr = 1'b0;

        // Reset in the middle of a stream holding three entries.
        idle(1'b0);
        cycle();
        while (q.size() > 0) begin
            idle(1'b1);
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b1, 1'b0, 3'(i), 1'b0);
            cycle();
        end
        apply_reset();
        idle(1'b1);
        cycle();
        drive(1'b1, 32'h1234, 1'b0, 1'b0, 1'b1, ALU_OP_XOR, 1'b0);
        cycle();
        idle(1'b1);
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
